// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the req/ack memory bus.
// Registered grant, one transaction per grant, plus a watchdog that aborts transactions the slave never acks.
module bus_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_out,
  output logic        m0_ack,
  output logic [31:0] m0_in,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_out,
  output logic        m1_ack,
  output logic [31:0] m1_in,
  output logic        s_req,
  output logic        s_wr,
  output logic [31:0] s_addr,
  output logic [31:0] s_out,
  input  logic        s_ack,
  input  logic [31:0] s_in,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              own, sel, sel_req, sel_wr, done, abort;
  logic [31:0]       sel_addr, sel_out;

  // NOTE: reset is synchronous, so the slave-facing outputs are also gated by rst to keep a
  // transaction from completing during the reset cycle itself.
  assign own      = rst && (state_q != IDLE);
  assign sel      = (state_q == OWN1);
  assign sel_req  = sel ? m1_req  : m0_req;
  assign sel_wr   = sel ? m1_wr   : m0_wr;
  assign sel_addr = sel ? m1_addr : m0_addr;
  assign sel_out  = sel ? m1_out  : m0_out;
  assign done     = own && sel_req && s_ack;
  assign abort    = own && sel_req && !s_ack && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only; all combinational logic lives in always_comb.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // NOTE: every variable gets a default at the top of each always_comb so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (m1_req) begin
          state_d = OWN1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        if (!sel_req || s_ack || (cnt_q == CNT_LAST)) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (err_clr) err_d = 1'b0;
    // An abort overrides a same-cycle clear and then records a fresh first-error address.
    if (abort) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_addr_d = sel_addr;
    end
  end

  always_comb begin
    s_req  = 1'b0;
    s_wr   = 1'b0;
    s_addr = '0;
    s_out  = '0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    m0_in  = '0;
    m1_in  = '0;
    if (own) begin
      s_req  = sel_req && !abort;
      s_wr   = sel_wr;
      s_addr = sel_addr;
      s_out  = sel_out;
      if (sel) begin
        m1_ack = done || abort;
        m1_in  = done ? s_in : (abort ? ERR_DATA : '0);
      end else begin
        m0_ack = done || abort;
        m0_in  = done ? s_in : (abort ? ERR_DATA : '0);
      end
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
